// File: rtl/word_select_encoder_pkg.sv
// word_select_encoder shared constants and types.
// Also used by the matching 4-to-16 word-select decoder.
package word_select_encoder_pkg;

  localparam int NUM_WORDS = 16;
  localparam int IDX_W     = 4;

  typedef logic [IDX_W-1:0]     word_idx_t;
  typedef logic [NUM_WORDS-1:0] lane_vec_t;

endpackage

// File: rtl/word_select_encoder_if.sv
// Valid/ready index stream from word_select_encoder.
// master = encoder side, slave = consumer side.
interface word_select_encoder_if;
  import word_select_encoder_pkg::*;

  word_idx_t word_o;
  logic      valid_o;
  logic      ready_i;

  modport master (
    output word_o,
    output valid_o,
    input  ready_i
  );

  modport slave (
    input  word_o,
    input  valid_o,
    output ready_i
  );

endinterface

// File: rtl/word_select_encoder_rr_pick16.sv
// rr_pick16: combinational round-robin picker.
// Finds the first set req bit scanning ptr, ptr+1, ... with wrap.
module rr_pick16
  import word_select_encoder_pkg::*;
(
  input  lane_vec_t req,
  input  word_idx_t ptr,
  output logic      any_o,
  output word_idx_t idx_o
);

  lane_vec_t rot;
  word_idx_t off;

  // rot[i] is the lane i steps after ptr
  always_comb begin
    rot = '0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      rot[i] = req[word_idx_t'(i) + ptr];
    end
  end

  always_comb begin
    off = '0;
    for (int i = NUM_WORDS - 1; i >= 0; i--) begin
      if (rot[i]) off = word_idx_t'(i);
    end
  end

  assign idx_o = off + ptr;
  assign any_o = |req;

endmodule

// File: rtl/word_select_encoder.sv
// Serialises 16 word-select strobes into a 4-bit index stream.
// Collision flag built only with WORD_SELECT_ENC_COLLISION_CHECK_EN.
module word_select_encoder
  import word_select_encoder_pkg::*;
#(
  parameter int NUM_WORDS_P = NUM_WORDS,
  parameter int IDX_W_P     = IDX_W
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  lane_vec_t                   word_select_i,
  word_select_encoder_if.master       out_if,
  output lane_vec_t                   pending_o,
  output logic                        error_o
);

  lane_vec_t pending;
  lane_vec_t cand;
  word_idx_t word_q;
  word_idx_t ptr;
  word_idx_t grant_idx;
  logic      valid_q;
  logic      grant_any;
  logic      load;

  assign cand = pending | word_select_i;
  assign load = !valid_q || out_if.ready_i;

  rr_pick16 u_pick (
    .req   (cand),
    .ptr   (ptr),
    .any_o (grant_any),
    .idx_o (grant_idx)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pending <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      ptr     <= '0;
    end else begin
      pending <= cand;
      if (load) begin
        if (grant_any) begin
          word_q  <= grant_idx;
          valid_q <= 1'b1;
          ptr     <= grant_idx + word_idx_t'(1);
          pending <= cand & ~(lane_vec_t'(1) << grant_idx);
        end else begin
          valid_q <= 1'b0;
        end
      end
    end
  end

`ifdef WORD_SELECT_ENC_COLLISION_CHECK_EN
  logic err_q;

  // A strobe on an already-pending lane merges and loses an event
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      err_q <= 1'b0;
    end else if (|(word_select_i & pending)) begin
      err_q <= 1'b1;
    end
  end

  assign error_o = err_q;
`else
  assign error_o = 1'b0;
`endif

  assign out_if.word_o  = word_q;
  assign out_if.valid_o = valid_q;
  assign pending_o      = pending;

endmodule

// File: tb/tb_word_select_encoder.sv
// Self-checking bench for word_select_encoder.
// Directed table, hand sequences, then random vs reference model.
module tb_word_select_encoder;
  import word_select_encoder_pkg::*;

`ifdef WORD_SELECT_ENC_COLLISION_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic      clk;
  logic      rst_n;
  lane_vec_t ws;
  lane_vec_t pend;
  logic      err;

  word_select_encoder_if bus ();

  word_select_encoder dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .word_select_i (ws),
    .out_if        (bus.master),
    .pending_o     (pend),
    .error_o       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit [15:0] m_pend;
  int        m_ptr;
  bit        m_valid;
  int        m_word;
  bit        m_err;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = '0; m_ptr = 0; m_valid = 0; m_word = 0; m_err = 0;
  endtask

  task automatic model_step(input bit [15:0] s, input bit r);
    bit [15:0] c;
    int g;
    c = m_pend | s;
    if (CHK && ((s & m_pend) != 0)) m_err = 1;
    if (!m_valid || r) begin
      g = -1;
      for (int k = 0; k < 16; k++) begin
        if (g < 0 && c[(m_ptr + k) % 16]) g = (m_ptr + k) % 16;
      end
      if (g >= 0) begin
        m_word = g; m_valid = 1; m_ptr = (g + 1) % 16;
        c[g] = 1'b0;
      end else begin
        m_valid = 0;
      end
    end
    m_pend = c;
  endtask

  task automatic cyc(input bit [15:0] s, input bit r);
    @(negedge clk);
    ws = s;
    bus.ready_i = r;
    @(posedge clk);
    model_step(s, r);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    ws = '0;
    bus.ready_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    bit [15:0] s;
    bit        r;
    bit        v;
    int        w;
    bit [15:0] p;
  } vec_t;

  vec_t tbl[7];
  int   n4;

  initial begin
    rst_n = 1'b0;
    ws = '0;
    bus.ready_i = 1'b0;
    model_reset();
    #12;
    chk("rst_valid", bus.valid_o, 0);
    chk("rst_word", bus.word_o, 0);
    chk("rst_pend", pend, 0);
    chk("rst_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // starts with ptr=0
    tbl[0] = '{16'h0020, 1, 1, 5, 16'h0000};
    tbl[1] = '{16'h0000, 1, 0, 5, 16'h0000};
    tbl[2] = '{16'h0001, 0, 1, 0, 16'h0000};
    tbl[3] = '{16'h0002, 0, 1, 0, 16'h0002};
    tbl[4] = '{16'h0004, 1, 1, 1, 16'h0004};
    tbl[5] = '{16'h0000, 1, 1, 2, 16'h0000};
    tbl[6] = '{16'h0000, 1, 0, 2, 16'h0000};
    for (int i = 0; i < 7; i++) begin
      cyc(tbl[i].s, tbl[i].r);
      chk($sformatf("tbl%0d_valid", i), bus.valid_o, tbl[i].v);
      chk($sformatf("tbl%0d_word", i), bus.word_o, tbl[i].w);
      chk($sformatf("tbl%0d_pend", i), pend, tbl[i].p);
    end

    // mid-stream reset with everything pending (ptr=3 here)
    cyc(16'hFFFF, 0);
    chk("mr_word", bus.word_o, 3);
    cyc(16'hFFFF, 0);
    chk("mr_pend", pend, 16'hFFFF);
    @(negedge clk);
    ws = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("mr_valid", bus.valid_o, 0);
    chk("mr_word0", bus.word_o, 0);
    chk("mr_pend0", pend, 0);
    chk("mr_err0", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    cyc(16'h0000, 1);
    chk("mr_stale_v", bus.valid_o, 0);
    chk("mr_stale_p", pend, 0);

    // all lanes from ptr=0
    cyc(16'hFFFF, 1);
    for (int i = 0; i < 16; i++) begin
      if (i > 0) cyc(16'h0000, 1);
      chk($sformatf("all_word%0d", i), bus.word_o, i);
      chk($sformatf("all_valid%0d", i), bus.valid_o, 1);
    end
    cyc(16'h0000, 1);
    chk("all_done", bus.valid_o, 0);

    // move ptr to 14, then wrap order 15,1,3
    cyc(16'h2000, 1);
    chk("wr_13", bus.word_o, 13);
    cyc(16'h0000, 1);
    cyc(16'h800A, 1);
    chk("wr_15", bus.word_o, 15);
    cyc(16'h0000, 1);
    chk("wr_1", bus.word_o, 1);
    cyc(16'h0000, 1);
    chk("wr_3", bus.word_o, 3);
    cyc(16'h0000, 1);
    chk("wr_end", bus.valid_o, 0);

    // backpressure: 9 held, 2 queued behind it
    cyc(16'h0200, 0);
    chk("bp_9", bus.word_o, 9);
    for (int i = 0; i < 5; i++) begin
      cyc(i == 0 ? 16'h0004 : 16'h0000, 0);
      chk($sformatf("bp_hold_w%0d", i), bus.word_o, 9);
      chk($sformatf("bp_hold_v%0d", i), bus.valid_o, 1);
    end
    chk("bp_pend", pend, 16'h0004);
    cyc(16'h0000, 1);
    chk("bp_2", bus.word_o, 2);
    chk("bp_2v", bus.valid_o, 1);
    cyc(16'h0000, 1);
    chk("bp_end", bus.valid_o, 0);

    // collision on lane 4
    cyc(16'h0001, 0);
    cyc(16'h0010, 0);
    chk("col_err_pre", err, 0);
    cyc(16'h0010, 0);
    chk("col_err", err, CHK);
    chk("col_pend", pend, 16'h0010);
    n4 = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(16'h0000, 1);
      if (bus.valid_o && bus.word_o == 4) n4++;
    end
    chk("col_count4", n4, 1);
    chk("col_sticky", err, CHK);

    // random against model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      bit [15:0] s;
      s = 16'($urandom) & 16'($urandom) & 16'($urandom);
      if ($urandom_range(0, 3) == 0) s = '0;
      cyc(s, 1'($urandom_range(0, 1)));
      chk("rnd_valid", bus.valid_o, m_valid);
      chk("rnd_word", bus.word_o, m_word);
      chk("rnd_pend", pend, m_pend);
      chk("rnd_err", err, m_err);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
